// File: rtl/pipe_ctrl_if.sv
// Pipeline hazard/divider/exception control bundle between the pipeline and pipe_ctrl.
// Latency: n/a (wires only).
// Backpressure: stall_o is the backpressure path toward the pipeline stages.
interface pipe_ctrl_if;
    logic        stallreq_id_i;
    logic        div_req_i;
    logic        div_ready_i;
    logic        excp_i;
    logic [31:0] excp_vec_i;
    logic [5:0]  stall_o;
    logic        div_start_o;
    logic        div_annul_o;
    logic        flush_o;
    logic [31:0] new_pc_o;
    logic        div_timeout_o;
    logic [31:0] stall_cnt_o;

    // Pipeline side: raises requests, obeys stall/flush.
    modport master (
        output stallreq_id_i, div_req_i, div_ready_i, excp_i, excp_vec_i,
        input  stall_o, div_start_o, div_annul_o, flush_o, new_pc_o,
        input  div_timeout_o, stall_cnt_o
    );

    // Controller side.
    modport slave (
        input  stallreq_id_i, div_req_i, div_ready_i, excp_i, excp_vec_i,
        output stall_o, div_start_o, div_annul_o, flush_o, new_pc_o,
        output div_timeout_o, stall_cnt_o
    );
endinterface

// File: rtl/pipe_ctrl.sv
// Pipeline stall/flush controller with divider handshake and divider watchdog.
// Latency: stall/start/annul combinational in the request cycle; flush and new_pc one cycle later.
// Backpressure: stall_o freezes {wb,mem,ex,id,if,pc}; exceptions override every stall.
module pipe_ctrl #(
    parameter int DIV_TIMEOUT = 63
) (
    input logic         clk,
    input logic         rst,
    pipe_ctrl_if.slave  bus
);
    typedef enum logic [1:0] {RUN, DIV_WAIT, FLUSH} state_t;

    localparam logic [5:0] STALL_DIV = 6'b001111;
    localparam logic [5:0] STALL_LU  = 6'b000111;
    localparam logic [5:0] WD_LAST   = 6'(DIV_TIMEOUT - 1);

    state_t      state, state_nxt;
    logic [5:0]  wd;
    logic [5:0]  stall;
    logic        start;
    logic        annul;
    logic        pc_ld;
    logic        wd_clr;
    logic        wd_inc;
    logic        timeout_set;
    logic [5:0]  stall_g;
    logic [31:0] new_pc;
    logic [31:0] stall_cnt;
    logic        div_timeout;

    always_comb begin
        state_nxt   = state;
        stall       = '0;
        start       = 1'b0;
        annul       = 1'b0;
        pc_ld       = 1'b0;
        wd_clr      = 1'b0;
        wd_inc      = 1'b0;
        timeout_set = 1'b0;
        case (state)
            RUN: begin
                if (bus.excp_i) begin
                    state_nxt = FLUSH;
                    pc_ld     = 1'b1;
                end else if (bus.div_req_i) begin
                    stall     = STALL_DIV;
                    start     = 1'b1;
                    wd_clr    = 1'b1;
                    state_nxt = DIV_WAIT;
                end else if (bus.stallreq_id_i) begin
                    stall     = STALL_LU;
                end
            end
            DIV_WAIT: begin
                // Exception beats a same-cycle divider result; the result is dropped.
                if (bus.excp_i) begin
                    annul     = 1'b1;
                    pc_ld     = 1'b1;
                    state_nxt = FLUSH;
                end else if (bus.div_ready_i) begin
                    state_nxt = RUN;
                end else if (wd == WD_LAST) begin
                    annul       = 1'b1;
                    timeout_set = 1'b1;
                    state_nxt   = RUN;
                end else begin
                    stall  = STALL_DIV;
                    wd_inc = 1'b1;
                end
            end
            FLUSH: state_nxt = RUN;
            default: state_nxt = RUN;
        endcase
    end

    // Reset holds the combinational outputs quiet even though RUN decodes live inputs.
    assign stall_g           = rst ? 6'b000000 : stall;
    assign bus.stall_o       = stall_g;
    assign bus.div_start_o   = start & ~rst;
    assign bus.div_annul_o   = annul & ~rst;
    assign bus.flush_o       = (state == FLUSH);
    assign bus.new_pc_o      = new_pc;
    assign bus.stall_cnt_o   = stall_cnt;
    assign bus.div_timeout_o = div_timeout;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= RUN;
            wd          <= '0;
            new_pc      <= '0;
            stall_cnt   <= '0;
            div_timeout <= 1'b0;
        end else begin
            state <= state_nxt;
            if (wd_clr)
                wd <= '0;
            else if (wd_inc)
                wd <= wd + 6'd1;
            if (pc_ld)
                new_pc <= bus.excp_vec_i;
            if (stall_g != 6'b000000)
                stall_cnt <= stall_cnt + 32'd1;
            if (timeout_set)
                div_timeout <= 1'b1;
        end
    end
endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: reset, load-use stall, divider wait/ready/exception/timeout, priority.
module tb_pipe_ctrl;
    logic clk = 1'b0;
    logic rst;
    int   n_cmp = 0;
    int   n_err = 0;

    pipe_ctrl_if bus ();

    pipe_ctrl #(.DIV_TIMEOUT(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        bus.stallreq_id_i = 1'b0;
        bus.div_req_i     = 1'b0;
        bus.div_ready_i   = 1'b0;
        bus.excp_i        = 1'b0;
        bus.excp_vec_i    = 32'h0;
    endtask

    initial begin
        rst = 1'b1;
        idle();
        step();
        // Requests during reset must not leak through.
        bus.stallreq_id_i = 1'b1;
        bus.div_req_i     = 1'b1;
        bus.excp_i        = 1'b1;
        #2;
        chk("rst_stall", 32'(bus.stall_o), 32'h0);
        chk("rst_start", 32'(bus.div_start_o), 32'h0);
        chk("rst_annul", 32'(bus.div_annul_o), 32'h0);
        chk("rst_flush", 32'(bus.flush_o), 32'h0);
        chk("rst_newpc", bus.new_pc_o, 32'h0);
        chk("rst_cnt", bus.stall_cnt_o, 32'h0);
        chk("rst_tmo", 32'(bus.div_timeout_o), 32'h0);
        step();
        idle();
        rst = 1'b0;

        for (int i = 0; i < 10; i++) begin
            step();
            chk("idle_stall", 32'(bus.stall_o), 32'h0);
            chk("idle_flush", 32'(bus.flush_o), 32'h0);
        end
        chk("idle_cnt", bus.stall_cnt_o, 32'h0);

        // Load-use stall for one cycle.
        bus.stallreq_id_i = 1'b1;
        #2;
        chk("lu_stall", 32'(bus.stall_o), 32'h07);
        chk("lu_start", 32'(bus.div_start_o), 32'h0);
        step();
        bus.stallreq_id_i = 1'b0;
        #2;
        chk("lu_after", 32'(bus.stall_o), 32'h0);
        chk("lu_flush", 32'(bus.flush_o), 32'h0);
        chk("lu_cnt", bus.stall_cnt_o, 32'd1);

        // Divide with result at cycle 5; div_req held in the ready cycle must not restart.
        step();
        bus.div_req_i = 1'b1;
        #2;
        chk("div0_start", 32'(bus.div_start_o), 32'h1);
        chk("div0_stall", 32'(bus.stall_o), 32'h0F);
        step();
        bus.div_req_i = 1'b0;
        for (int c = 1; c <= 4; c++) begin
            #2;
            chk("divw_stall", 32'(bus.stall_o), 32'h0F);
            chk("divw_start", 32'(bus.div_start_o), 32'h0);
            step();
        end
        bus.div_ready_i = 1'b1;
        bus.div_req_i   = 1'b1;
        #2;
        chk("divr_stall", 32'(bus.stall_o), 32'h0);
        chk("divr_start", 32'(bus.div_start_o), 32'h0);
        chk("divr_annul", 32'(bus.div_annul_o), 32'h0);
        step();
        idle();
        #2;
        chk("divr_run", 32'(bus.stall_o), 32'h0);
        chk("divr_cnt", bus.stall_cnt_o, 32'd6);

        // Exception (with simultaneous ready) in the 3rd DIV_WAIT cycle.
        step();
        bus.div_req_i = 1'b1;
        step();
        bus.div_req_i = 1'b0;
        step();
        step();
        bus.excp_i      = 1'b1;
        bus.div_ready_i = 1'b1;
        bus.excp_vec_i  = 32'hBFC0_0380;
        #2;
        chk("dx_annul", 32'(bus.div_annul_o), 32'h1);
        chk("dx_stall", 32'(bus.stall_o), 32'h0);
        chk("dx_start", 32'(bus.div_start_o), 32'h0);
        step();
        idle();
        #2;
        chk("dx_flush", 32'(bus.flush_o), 32'h1);
        chk("dx_newpc", bus.new_pc_o, 32'hBFC0_0380);
        chk("dx_fl_stall", 32'(bus.stall_o), 32'h0);
        chk("dx_fl_annul", 32'(bus.div_annul_o), 32'h0);
        step();
        chk("dx_run", 32'(bus.flush_o), 32'h0);
        chk("dx_cnt", bus.stall_cnt_o, 32'd9);

        // Watchdog: no ready, abort on the 8th DIV_WAIT cycle.
        bus.div_req_i = 1'b1;
        step();
        bus.div_req_i = 1'b0;
        for (int c = 1; c <= 7; c++) begin
            #2;
            chk("wd_stall", 32'(bus.stall_o), 32'h0F);
            chk("wd_annul", 32'(bus.div_annul_o), 32'h0);
            step();
        end
        #2;
        chk("wd_fire", 32'(bus.div_annul_o), 32'h1);
        chk("wd_fire_stall", 32'(bus.stall_o), 32'h0);
        chk("wd_pre_tmo", 32'(bus.div_timeout_o), 32'h0);
        step();
        bus.stallreq_id_i = 1'b1;
        #2;
        chk("wd_tmo", 32'(bus.div_timeout_o), 32'h1);
        chk("wd_run", 32'(bus.stall_o), 32'h07);
        step();
        idle();
        step();
        step();
        chk("wd_hold", 32'(bus.div_timeout_o), 32'h1);
        chk("wd_cnt", bus.stall_cnt_o, 32'd18);

        // All requests at once in RUN: exception wins.
        bus.excp_i        = 1'b1;
        bus.div_req_i     = 1'b1;
        bus.stallreq_id_i = 1'b1;
        bus.excp_vec_i    = 32'h8000_0180;
        #2;
        chk("all_stall", 32'(bus.stall_o), 32'h0);
        chk("all_start", 32'(bus.div_start_o), 32'h0);
        step();
        idle();
        #2;
        chk("all_flush", 32'(bus.flush_o), 32'h1);
        chk("all_newpc", bus.new_pc_o, 32'h8000_0180);
        step();
        chk("all_run", 32'(bus.flush_o), 32'h0);
        chk("all_cnt", bus.stall_cnt_o, 32'd18);

        // Reset in DIV_WAIT: back to RUN, no annul, counters cleared.
        bus.div_req_i = 1'b1;
        step();
        bus.div_req_i = 1'b0;
        rst = 1'b1;
        #2;
        chk("rdw_annul", 32'(bus.div_annul_o), 32'h0);
        chk("rdw_stall", 32'(bus.stall_o), 32'h0);
        chk("rdw_cnt", bus.stall_cnt_o, 32'h0);
        chk("rdw_tmo", 32'(bus.div_timeout_o), 32'h0);
        chk("rdw_newpc", bus.new_pc_o, 32'h0);
        step();
        rst = 1'b0;
        step();
        chk("rdw_run_stall", 32'(bus.stall_o), 32'h0);
        chk("rdw_run_flush", 32'(bus.flush_o), 32'h0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
